// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state type, framing constants and per-quarter line levels
package i2c_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, ACK, STOP, FREE} i2c_state_t;
    localparam int BYTES_PER_WRITE = 3;
    localparam int QUARTERS_PER_BIT = 4;
    // {sda, scl} for a given state, quarter and current data bit
    function automatic logic [1:0] bus_levels(i2c_state_t st, logic [1:0] q, logic b);
        return st == START ? {q == 2'd0, q != 2'd3} :
               st == DATA  ? {b, q[0] ^ q[1]} :
               st == ACK   ? {1'b1, q[0] ^ q[1]} :
               st == STOP  ? {q[1], q != 2'd0} : 2'b11;
    endfunction
endpackage

// File: rtl/i2c_quarter_tick.sv
// i2c_quarter_tick: one-clk tick every QUARTER_CYCLES clks, held at zero while disabled
module i2c_quarter_tick #(
    parameter int QUARTER_CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);
    localparam int CW = QUARTER_CYCLES > 1 ? $clog2(QUARTER_CYCLES) : 1;
    logic [CW-1:0] cnt;
    assign tick = en && cnt == CW'(QUARTER_CYCLES - 1);
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt <= '0;
        else cnt <= (en && !tick) ? cnt + 1'b1 : '0;
endmodule

// File: rtl/i2c_reg_writer.sv
// i2c_reg_writer: single register write (START, addr, reg, data, STOP) over open-drain SDA
module i2c_reg_writer
    import i2c_pkg::*;
#(
    parameter int QUARTER_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       nack,
    output logic [1:0] nack_byte,
    input  logic       sda_in,
    output logic       sda_out,
    output logic       scl
);
    localparam int SW = BYTES_PER_WRITE * 8;
    i2c_state_t state, state_n;
    logic [1:0] q, q_n, byte_cnt, byte_n, nack_idx, nack_idx_n;
    logic [2:0] bit_cnt, bit_n;
    logic [SW-1:0] shreg, sh_n;
    logic nack_flag, nack_flag_n, ack_smp, ack_n, done_n, sda_n, scl_n, tick, last_q, hs;

    i2c_quarter_tick #(.QUARTER_CYCLES(QUARTER_CYCLES)) u_tick (
        .clk  (clk),
        .reset(reset),
        .en   (state != IDLE),
        .tick (tick)
    );

    assign req_ready = state == IDLE && !reset;
    assign hs = req_valid && req_ready;
    assign last_q = tick && q == 2'(QUARTERS_PER_BIT - 1);
    assign busy = state != IDLE || done;
    assign nack = done && nack_flag;
    assign nack_byte = nack ? nack_idx : 2'd0;

    always_comb begin
        state_n = state;
        q_n = tick ? q + 2'd1 : q;
        bit_n = bit_cnt;
        byte_n = byte_cnt;
        sh_n = shreg;
        nack_flag_n = nack_flag;
        nack_idx_n = nack_idx;
        ack_n = ack_smp;
        done_n = 1'b0;
        case (state)
            IDLE: if (hs) begin
                state_n = START;
                q_n = '0;
                sh_n = {dev_addr, 1'b0, reg_addr, wdata};
                bit_n = '0;
                byte_n = '0;
                nack_flag_n = 1'b0;
                nack_idx_n = '0;
            end
            START: if (last_q) state_n = DATA;
            DATA: if (last_q) begin
                sh_n = shreg << 1;
                bit_n = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) state_n = ACK;
            end
            ACK: begin
                // target's answer is taken on the last clk of the second SCL-high quarter
                if (tick && q == 2'd2) ack_n = sda_in;
                if (last_q) begin
                    if (ack_smp) begin
                        nack_flag_n = 1'b1;
                        nack_idx_n = byte_cnt;
                        state_n = STOP;
                    end else if (byte_cnt == 2'(BYTES_PER_WRITE - 1)) state_n = STOP;
                    else begin
                        byte_n = byte_cnt + 2'd1;
                        state_n = DATA;
                    end
                end
            end
            STOP: if (last_q) state_n = FREE;
            FREE: if (last_q) begin
                state_n = IDLE;
                done_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    assign {sda_n, scl_n} = bus_levels(state_n, q_n, sh_n[SW-1]);

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            q <= '0;
            bit_cnt <= '0;
            byte_cnt <= '0;
            shreg <= '0;
            nack_flag <= 1'b0;
            nack_idx <= '0;
            ack_smp <= 1'b0;
            done <= 1'b0;
            sda_out <= 1'b1;
            scl <= 1'b1;
        end else begin
            state <= state_n;
            q <= q_n;
            bit_cnt <= bit_n;
            byte_cnt <= byte_n;
            shreg <= sh_n;
            nack_flag <= nack_flag_n;
            nack_idx <= nack_idx_n;
            ack_smp <= ack_n;
            done <= done_n;
            sda_out <= sda_n;
            scl <= scl_n;
        end
endmodule

// File: tb/tb_i2c_reg_writer.sv
// tb_i2c_reg_writer: directed checks of the I2C write engine at QUARTER_CYCLES 1 and 3
module tb_i2c_reg_writer;
    logic clk = 0, reset = 0, req_valid = 0, sel = 0, tgt_low = 0;
    logic [6:0] dev_addr = '0;
    logic [7:0] reg_addr = '0, wdata = '0;
    logic rdy1, busy1, done1, nack1, sda_out1, scl1, sda_in1;
    logic rdy3, busy3, done3, nack3, sda_out3, scl3, sda_in3;
    logic [1:0] nb1, nb3;
    logic rdy, busy, done, nack, sda_o, sda_b, scl_b;
    logic [1:0] nack_byte;
    int nack_at = 3, errors = 0, checks = 0;
    int bitn = 0, starts = 0, stops = 0, hi_chg = 0, hi_t = 0, ncyc = 0;
    int hi_min = 999, hi_max = 0, done_cnt = 0;
    logic scl_p = 1, sda_p = 1;
    logic [7:0] rxb [3];

    always #5 clk = ~clk;

    assign sda_in1 = sda_out1 & ~(tgt_low & ~sel);
    assign sda_in3 = sda_out3 & ~(tgt_low & sel);
    assign rdy = sel ? rdy3 : rdy1;
    assign busy = sel ? busy3 : busy1;
    assign done = sel ? done3 : done1;
    assign nack = sel ? nack3 : nack1;
    assign nack_byte = sel ? nb3 : nb1;
    assign sda_o = sel ? sda_out3 : sda_out1;
    assign sda_b = sel ? sda_in3 : sda_in1;
    assign scl_b = sel ? scl3 : scl1;

    i2c_reg_writer #(.QUARTER_CYCLES(1)) u_q1 (
        .clk(clk), .reset(reset), .req_valid(req_valid & ~sel), .req_ready(rdy1),
        .dev_addr(dev_addr), .reg_addr(reg_addr), .wdata(wdata), .busy(busy1), .done(done1),
        .nack(nack1), .nack_byte(nb1), .sda_in(sda_in1), .sda_out(sda_out1), .scl(scl1)
    );

    i2c_reg_writer #(.QUARTER_CYCLES(3)) u_q3 (
        .clk(clk), .reset(reset), .req_valid(req_valid & sel), .req_ready(rdy3),
        .dev_addr(dev_addr), .reg_addr(reg_addr), .wdata(wdata), .busy(busy3), .done(done3),
        .nack(nack3), .nack_byte(nb3), .sda_in(sda_in3), .sda_out(sda_out3), .scl(scl3)
    );

    // bus monitor and target model: decodes START/STOP, collects bits, ACKs unless told to NACK
    always @(negedge clk) begin
        if (reset) begin
            tgt_low <= 1'b0;
            bitn <= 0;
            hi_min <= 999;
            hi_max <= 0;
        end else begin
            if (scl_b && scl_p && sda_b != sda_p) begin
                hi_chg <= hi_chg + 1;
                if (!sda_b) begin
                    starts <= starts + 1;
                    bitn <= 0;
                    for (int i = 0; i < 3; i++) rxb[i] <= 8'h00;
                end else stops <= stops + 1;
            end
            if (scl_b && !scl_p) begin
                if (bitn % 9 != 8 && bitn < 27) rxb[bitn / 9] <= {rxb[bitn / 9][6:0], sda_b};
                bitn <= bitn + 1;
                hi_t <= ncyc;
            end
            if (!scl_b && scl_p) begin
                tgt_low <= (bitn % 9 == 8) && (bitn / 9 != nack_at);
                if (bitn != 0 && ncyc - hi_t < hi_min) hi_min <= ncyc - hi_t;
                if (bitn != 0 && ncyc - hi_t > hi_max) hi_max <= ncyc - hi_t;
            end
        end
        if (done) done_cnt <= done_cnt + 1;
        scl_p <= scl_b;
        sda_p <= sda_b;
        ncyc <= ncyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // one transaction from a negedge in IDLE/done cycle; returns at the negedge of the done cycle
    task automatic xfer(input logic [6:0] d, input logic [7:0] r, input logic [7:0] w,
                        input int nk, input bit keep, input string tag);
        int lat, s0, p0, c0, bad, qc, exp_lat;
        qc = sel ? 3 : 1;
        exp_lat = (nk < 3 ? 4 + 36 * (nk + 1) + 8 : 120) * qc;
        nack_at = nk;
        req_valid = 1;
        dev_addr = d;
        reg_addr = r;
        wdata = w;
        @(posedge clk);
        s0 = starts;
        p0 = stops;
        c0 = hi_chg;
        @(negedge clk);
        chk({tag, "/busy0"}, busy, 1);
        chk({tag, "/ready0"}, rdy, 0);
        req_valid = keep;
        dev_addr = ~d;
        reg_addr = ~r;
        wdata = ~w;
        lat = 0;
        bad = 0;
        while (!done && lat < 3000) begin
            @(negedge clk);
            lat++;
            if (rdy && !done) bad++;
        end
        chk({tag, "/latency"}, lat, exp_lat);
        chk({tag, "/ready_done"}, rdy, 1);
        chk({tag, "/busy_done"}, busy, 1);
        chk({tag, "/nack"}, nack, nk < 3);
        chk({tag, "/nack_byte"}, nack_byte, nk < 3 ? nk : 0);
        chk({tag, "/ready_while_busy"}, bad, 0);
        chk({tag, "/starts"}, starts - s0, 1);
        chk({tag, "/stops"}, stops - p0, 1);
        chk({tag, "/sda_chg_scl_hi"}, hi_chg - c0, 2);
    endtask

    initial begin
        int n, d0;
        #1 reset = 1;
        #1;
        chk("rst/sda", sda_o, 1);
        chk("rst/scl", scl_b, 1);
        chk("rst/busy", busy, 0);
        chk("rst/done", done, 0);
        chk("rst/nack", nack, 0);
        chk("rst/nack_byte", nack_byte, 0);
        repeat (2) @(negedge clk);
        reset = 0;
        @(negedge clk);
        chk("rst/ready", rdy, 1);

        xfer(7'h39, 8'h41, 8'h10, 3, 0, "basic");
        chk("basic/bytes", {8'h00, rxb[0], rxb[1], rxb[2]}, 32'h0072_4110);
        @(negedge clk);
        chk("basic/done_pulse", done, 0);
        chk("basic/busy_after", busy, 0);

        xfer(7'h39, 8'h41, 8'h10, 0, 0, "nack0");
        chk("nack0/addr_byte", rxb[0], 8'h72);
        @(negedge clk);
        xfer(7'h2A, 8'hC3, 8'h5E, 2, 0, "nack2");
        chk("nack2/bytes", {8'h00, rxb[0], rxb[1], rxb[2]}, 32'h0054_C35E);
        @(negedge clk);

        xfer(7'h12, 8'h34, 8'h56, 3, 1, "b2b1");
        chk("b2b1/bytes", {8'h00, rxb[0], rxb[1], rxb[2]}, 32'h0024_3456);
        xfer(7'h5B, 8'hA7, 8'h0F, 3, 0, "b2b2");
        chk("b2b2/bytes", {8'h00, rxb[0], rxb[1], rxb[2]}, 32'h00B6_A70F);
        @(negedge clk);

        nack_at = 3;
        req_valid = 1;
        dev_addr = 7'h39;
        reg_addr = 8'h41;
        wdata = 8'h10;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        n = 0;
        while (!(bitn >= 10 && bitn <= 17 && !scl_b && !sda_b) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("midrst/reached_byte1", n < 500, 1);
        d0 = done_cnt;
        #1 reset = 1;
        #1;
        chk("midrst/sda", sda_o, 1);
        chk("midrst/scl", scl_b, 1);
        repeat (3) @(negedge clk);
        chk("midrst/busy", busy, 0);
        reset = 0;
        repeat (200) @(negedge clk);
        chk("midrst/no_done", done_cnt - d0, 0);
        chk("midrst/ready", rdy, 1);
        xfer(7'h39, 8'h41, 8'h10, 3, 0, "after_rst");
        chk("after_rst/bytes", {8'h00, rxb[0], rxb[1], rxb[2]}, 32'h0072_4110);
        @(negedge clk);

        reset = 1;
        sel = 1;
        repeat (2) @(negedge clk);
        reset = 0;
        @(negedge clk);
        xfer(7'h39, 8'h41, 8'h10, 3, 0, "q3");
        chk("q3/bytes", {8'h00, rxb[0], rxb[1], rxb[2]}, 32'h0072_4110);
        chk("q3/scl_hi_min", hi_min, 6);
        chk("q3/scl_hi_max", hi_max, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/i2c_reg_writer.md
# i2c_reg_writer

Byte-level I2C write engine for the ADV7513 configuration path. It accepts one register-write request at a time (7-bit device address, 8-bit register address, 8-bit data) over a valid/ready handshake. It then performs a complete START / 3 bytes + ACK / STOP transaction on the SCL and SDA lines and reports completion or NACK. It sits between the HDMI configuration sequencer, which issues the requests, and the SDA open-drain pin buffer and push-pull SCL output.

## Interface
- QUARTER_CYCLES, 1: clk cycles per quarter SCL bit period, range ≥1. At the 195.3 kHz I2C clock (50 MHz/256), 1 gives SCL ≈ 48.8 kHz.
- clk  in  1  I2C engine clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  engine idle and able to accept a request.
- dev_addr  in  7  target device address. Captured on handshake.
- reg_addr  in  8  register address. Captured on handshake.
- wdata  in  8  register data. Captured on handshake.
- busy  out  1  transaction in progress, from handshake until done.
- done  out  1  one-cycle pulse when the transaction finishes.
- nack  out  1  valid with done: 1 means a byte was not acknowledged.
- nack_byte  out  2  valid with done when nack=1: index of the byte that was NACKed (0 = address, 1 = register, 2 = data). Otherwise 0.
- sda_in  in  1  sampled SDA level.
- sda_out  out  1  SDA drive. 0 pulls the line low, 1 releases it.
- scl  out  1  SCL level, push-pull.

## Operation
- The design has one clock and an asynchronous, active-high reset.
- **Handshake:** a request is accepted on any rising edge where req_valid && req_ready. The inputs are captured into a 3-byte shift register in this order:
  - byte 0 = {dev_addr, 1'b0}
  - byte 1 = reg_addr
  - byte 2 = wdata
  - Each byte is sent MSB first.
  - Upstream may change the inputs after the handshake.
- **Quarter timing:** a quarter tick occurs every QUARTER_CYCLES clks. Each state lasts a whole number of quarters, indexed q0–q3.
- **States:** IDLE, START, DATA, ACK, STOP, FREE.
- **IDLE:** SDA and SCL are both 1 and req_ready=1. On handshake, go to START.
- **START** (SDA/SCL per quarter): q0 1/1, q1 0/1, q2 0/1, q3 0/0. Then go to DATA with byte 0, bit 7.
- **DATA bit:**
  - q0: SCL=0 and SDA = current bit.
  - q1, q2: SCL=1.
  - q3: SCL=0.
  - After bit 0, go to ACK.
- **ACK:**
  - SDA is released (1), with the same SCL pattern as a DATA bit.
  - sda_in is sampled on the last clk of q2. A sampled 1 means NACK.
  - On ACK: go to the next byte. After byte 2, go to STOP.
  - On NACK: record the byte index, set the sticky NACK flag, and go to STOP immediately.
- **STOP** (SDA/SCL per quarter): q0 0/0, q1 0/1, q2 1/1, q3 1/1.
- **FREE:** 4 quarters with both lines at 1 (bus free time). On the final clk, return to IDLE, pulse done, and present nack and nack_byte.
- SDA changes only while SCL=0, except during the START and STOP edges.
- sda_out and scl are registered outputs, with no combinational path from the inputs.

## Timing
- Reset values: sda_out=1, scl=1, busy=0, done=0, nack=0, nack_byte=0, state=IDLE. req_ready=1 once reset deasserts.
- Reset mid-transaction releases both lines asynchronously and abandons the transaction. No done pulse is produced. The sequencer is responsible for re-issuing the request.
- Full transaction = START 4 + 27 bits × 4 + STOP 4 + FREE 4 = 120 quarters. If the handshake is at edge 0, done is high in cycle 120·QUARTER_CYCLES.
- NACK on byte k: done at (4 + 36·(k+1) + 8)·QUARTER_CYCLES.
- done and req_ready are high in the same cycle, so a back-to-back request may be accepted in that cycle.
- busy=1 from the cycle after the handshake through the done cycle inclusive.
- req_ready=0 whenever busy=1, apart from the done cycle.
- req_valid while not ready is ignored. No request is queued.

## Structure
- Package i2c_pkg holds:
  - the i2c_state_t enum (IDLE, START, DATA, ACK, STOP, FREE)
  - BYTES_PER_WRITE = 3
  - QUARTERS_PER_BIT = 4
- Sub-module i2c_quarter_tick: a counter modulo QUARTER_CYCLES that emits a one-clk tick. It resets to 0 and holds at 0 while in IDLE.
- The FSM, the 3-byte shift register, the 3-bit bit counter, the 2-bit byte counter, the 2-bit quarter counter, and the sticky NACK flag all live in the top module.

## Test plan
- **Basic write, all ACKs:** reset, then request dev 0x39, reg 0x41, data 0x10, with the target model always ACKing. Required response:
  - SDA bit stream after START is 0x72, 0x41, 0x10.
  - Correct START and STOP edges.
  - done at cycle 120·Q with nack=0.
- **NACK on address:** the target releases SDA at ACK 0. Required response: STOP follows immediately, done at cycle 48·Q, nack=1, nack_byte=0.
- **NACK on data:** the target NACKs byte 2. Required response: done at cycle 120·Q, nack=1, nack_byte=2.
- **Back-to-back requests:** req_valid is held with two requests. Required response: the second handshake happens in the done cycle of the first, and the two transactions are separated by exactly 4 FREE quarters.
- **Reset mid-transaction:** assert reset during byte 1 and check:
  - sda_out=1 and scl=1 within the same cycle.
  - No done pulse.
  - A fresh request after reset completes normally.
- **QUARTER_CYCLES=3:** repeat the basic write. Required response:
  - SCL high time is 6 clks.
  - done at cycle 360.
  - SDA never changes while SCL=1 except at START and STOP.
